// File: rtl/configurable_multiplier_seq.sv
// Iterative sign-magnitude chunk multiplier: one chunk partial product per cycle into an accumulator.
// Optional macro CMULT_STICKY_EN adds a sticky output flagging bits discarded by the shifts.
module configurable_multiplier_seq #(
    parameter int CW = 2,
    parameter int NC = 4,
    parameter int OW = 2,
    parameter int AW = 17
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic [NC*CW-1:0]     x,
    input  logic [NC*CW-1:0]     y,
    input  logic [NC-1:0]        xs,
    input  logic [NC-1:0]        ys,
    input  logic [NC*OW-1:0]     xo,
    input  logic [NC*OW-1:0]     yo,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef CMULT_STICKY_EN
    output logic                 sticky,
`endif
    output logic [AW-1:0]        result
);

    localparam int PW   = 2*CW + 1;
    localparam int FW   = 4*CW + 1;
    localparam int CNTW = $clog2(NC + 1);
    localparam logic [CNTW-1:0] LAST = CNTW'(NC);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [CNTW-1:0]   cnt;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     term_q;
    logic [1:0]        mode_q;
    logic [NC*CW-1:0]  x_q, y_q;
    logic [NC-1:0]     xs_q, ys_q;
    logic [NC*OW-1:0]  xo_q, yo_q;

    logic [CNTW-1:0]   idx;
    logic [CW-1:0]     xc, yc;
    logic [OW-1:0]     xoc, yoc;
    logic [2*CW-1:0]   prod;
    logic [PW-1:0]     pmag, psgn;
    logic [FW-1:0]     f, f_m;
    logic [AW-1:0]     ext, term;
    logic [OW:0]       shamt;
    int unsigned       msh;

    // The flush cycle (cnt == LAST) has no chunk; point at chunk 0 to stay in range.
    always_comb begin
        idx   = (cnt == LAST) ? '0 : cnt;
        xc    = x_q[idx*CW +: CW];
        yc    = y_q[idx*CW +: CW];
        xoc   = xo_q[idx*OW +: OW];
        yoc   = yo_q[idx*OW +: OW];
        prod  = {{CW{1'b0}}, xc} * {{CW{1'b0}}, yc};
        pmag  = {1'b0, prod};
        psgn  = (xs_q[idx] ^ ys_q[idx]) ? -pmag : pmag;
        f     = {psgn, {(2*CW){1'b0}}};
        case (mode_q)
            2'b00:   msh = 0;
            2'b01:   msh = CW;
            default: msh = (idx == '0) ? 2*CW : CW;
        endcase
        f_m   = f >> msh;
        shamt = mode_q[1] ? '0 : ({1'b0, xoc} + {1'b0, yoc});
        ext   = '0;
        ext[FW-1:0] = f_m;
        term  = ext >> shamt;
    end

`ifdef CMULT_STICKY_EN
    logic sticky_q;
    logic lost;

    always_comb begin
        lost = (|(f & ~({FW{1'b1}} << msh))) | (|(ext & ~({AW{1'b1}} << shamt)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sticky_q <= 1'b0;
        end else if (state == BUSY && cnt != LAST) begin
            sticky_q <= sticky_q | lost;
        end
    end

    assign sticky = sticky_q;
`endif

    // Terms are registered one cycle before accumulation, so BUSY lasts NC+1 cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            term_q <= '0;
            mode_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            xs_q   <= '0;
            ys_q   <= '0;
            xo_q   <= '0;
            yo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_q <= mode;
                        x_q    <= x;
                        y_q    <= y;
                        xs_q   <= xs;
                        ys_q   <= ys;
                        xo_q   <= xo;
                        yo_q   <= yo;
                        acc    <= '0;
                        cnt    <= '0;
                        term_q <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc + term_q;
                    if (cnt == LAST) begin
                        term_q <= '0;
                        state  <= DONE;
                    end else begin
                        term_q <= term;
                        cnt    <= cnt + CNTW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_configurable_multiplier_seq.sv
// Directed-vector bench for configurable_multiplier_seq with hand-computed results.
module tb_configurable_multiplier_seq;

    localparam int CW = 2;
    localparam int NC = 4;
    localparam int OW = 2;
    localparam int AW = 17;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        mode;
    logic [NC*CW-1:0]  x, y;
    logic [NC-1:0]     xs, ys;
    logic [NC*OW-1:0]  xo, yo;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     result;
`ifdef CMULT_STICKY_EN
    logic              sticky;
`endif

    int n_vec;
    int n_miscompare;

    configurable_multiplier_seq #(
        .CW(CW),
        .NC(NC),
        .OW(OW),
        .AW(AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x         (x),
        .y         (y),
        .xs        (xs),
        .ys        (ys),
        .xo        (xo),
        .yo        (yo),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef CMULT_STICKY_EN
        .sticky    (sticky),
`endif
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_ops(input logic [1:0] m, input logic [15:0] xv, input logic [15:0] yv,
                             input logic [3:0] xsv, input logic [3:0] ysv,
                             input logic [7:0] xov, input logic [7:0] yov);
        mode = m;
        x    = xv;
        y    = yv;
        xs   = xsv;
        ys   = ysv;
        xo   = xov;
        yo   = yov;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic start_op(input string tag, input logic [1:0] m, input logic [15:0] xv,
                            input logic [15:0] yv, input logic [3:0] xsv, input logic [3:0] ysv,
                            input logic [7:0] xov, input logic [7:0] yov);
        drive_ops(m, xv, yv, xsv, ysv, xov, yov);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_accepted"}, 32'(in_ready), 32'd0);
    endtask

    task automatic wait_result(input string tag, input int exp_res, input logic exp_sticky);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (!out_valid && k < 20);
        check({tag, "_latency"}, 32'(k), 32'(NC + 1));
        check({tag, "_result"}, 32'(result), 32'(exp_res));
`ifdef CMULT_STICKY_EN
        check({tag, "_sticky"}, 32'(sticky), 32'(exp_sticky));
`else
        if (exp_sticky === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_hs_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_hs_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int stale;
        n_vec        = 0;
        n_miscompare = 0;
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        drive_ops(2'b00, '0, '0, '0, '0, '0, '0);
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // hi: 3*3 in chunk 0, offsets ignored -> 9
        start_op("hi", 2'b10, 16'h0003, 16'h0003, 4'h0, 4'h0, 8'h03, 8'h03);
        wait_result("hi", 9, 1'b0);
        handshake("hi");

        // lo: -(3*2) -> F=416, >>2 -> 104
        start_op("lo_neg", 2'b00, 16'h0003, 16'h0002, 4'h1, 4'h0, 8'h01, 8'h01);
        wait_result("lo_neg", 104, 1'b0);
        handshake("lo_neg");

        // med: four chunks of 1*1 -> 4 each
        start_op("med", 2'b01, 16'h5555, 16'h5555, 4'h0, 4'h0, 8'h00, 8'h00);
        wait_result("med", 16, 1'b0);
        handshake("med");

        // mode 11 as hi: chunk0 16>>4=1, others 16>>2=4 -> 13; offsets ignored
        start_op("m11", 2'b11, 16'h5555, 16'h5555, 4'h0, 4'h0, 8'hFF, 8'hFF);
        wait_result("m11", 13, 1'b0);
        handshake("m11");

        // lo all negative 3*3: 4 * (23<<4) = 1472
        start_op("lo_all", 2'b00, 16'hFFFF, 16'hFFFF, 4'hF, 4'h0, 8'h00, 8'h00);
        wait_result("lo_all", 1472, 1'b0);
        handshake("lo_all");

        // back-pressure: result held while out_ready low, in_valid ignored
        start_op("hold", 2'b01, 16'h5555, 16'h5555, 4'h0, 4'h0, 8'h00, 8'h00);
        wait_result("hold", 16, 1'b0);
        drive_ops(2'b10, 16'h0003, 16'h0003, 4'h0, 4'h0, 8'h00, 8'h00);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_result", 32'(result), 32'd16);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("no_bypass_in_ready", 32'(in_ready), 32'd1);
        check("no_bypass_out_valid", 32'(out_valid), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("not_queued_in_ready", 32'(in_ready), 32'd1);
        end
        start_op("represent", 2'b10, 16'h0003, 16'h0003, 4'h0, 4'h0, 8'h00, 8'h00);
        wait_result("represent", 9, 1'b0);
        handshake("represent");

        // reset while counter is 2 in BUSY
        start_op("abort", 2'b01, 16'h5555, 16'h5555, 4'h0, 4'h0, 8'h00, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_result", 32'(result), 32'd0);
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("abort_no_stale", 32'(stale), 32'd0);
        check("abort_idle", 32'(in_ready), 32'd1);

        // offsets 3+3 = 6 without wrap: 16>>6 = 0, bit discarded
        start_op("off6", 2'b00, 16'h0001, 16'h0001, 4'h0, 4'h0, 8'h03, 8'h03);
        wait_result("off6", 0, 1'b1);
        handshake("off6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
